mmm_mac_writeback: RTL and testbench
====================================

Name: mmm_mac_writeback

Overview:
- Datapath stage directly downstream of the matrix-multiply address FSM.
- Consumes the operand words returned by the A/B matrix memories for the FSM-issued addresses, together with the FSM's mac_enable and addr_c.
- Multiplies and accumulates MATRIX_DIM products per output element, then issues a one-cycle write of the finished dot product into C memory.
- Aligns control with memory read latency internally, so the FSM needs no changes.

Parameters:
- MATRIX_DIM, 8, matrix side length; dot-product length per C element.
- ADDR_WIDTH, 6, C address width; must be at least clog2(MATRIX_DIM**2).
- DATA_WIDTH, 8, signed operand width of A and B words.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MATRIX_DIM), signed accumulator / C word width.
- READ_LATENCY, 1, A/B memory read latency in cycles (range 1..4).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of in-flight work; pulsed when a new multiply starts.
- mac_enable  input  1  from FSM: the A/B addresses issued this cycle form a valid term.
- addr_c  input  ADDR_WIDTH  from FSM: C index the current term belongs to.
- a_data  input  DATA_WIDTH  signed A word, valid READ_LATENCY cycles after its address.
- b_data  input  DATA_WIDTH  signed B word, same timing as a_data.
- c_we  output  1  C memory write strobe, one-cycle pulse.
- c_addr  output  ADDR_WIDTH  C write address.
- c_data  output  ACC_WIDTH  signed C write data.
- done  output  1  one-cycle pulse coincident with the write of element MATRIX_DIM**2-1.

Behaviour:
- Reset: c_we=0, done=0, c_addr=0, c_data=0. All delay-line and pipeline valids cleared, accumulator=0, term counter k=0.
- Alignment: mac_enable and addr_c pass through a READ_LATENCY-deep shift register, giving en_d and addr_d, which are cycle-aligned with a_data/b_data.
- Term counter k, width clog2(MATRIX_DIM):
  - Increments only on en_d; wraps MATRIX_DIM-1 -> 0.
  - first = (k==0); last = (k==MATRIX_DIM-1).
  - Gaps in mac_enable hold k, the accumulator and the pipeline registers.
- Stage P (product):
  - On en_d, register p = a_data*b_data as a signed full 2*DATA_WIDTH product, plus valid_p, first_p, last_p and addr_p.
  - Otherwise valid_p=0.
- Stage A (accumulate): on valid_p, acc <= (first_p ? 0 : acc) + sign-extended p.
  - ACC_WIDTH is sized so overflow is impossible; no saturation logic.
- Writeback: on valid_p && last_p, the next cycle has c_we=1, c_data = final sum (the acc value including p), c_addr = addr_p.
  - c_we is 0 in every other cycle.
  - c_data and c_addr hold their last written values while c_we=0.
- done=1 exactly when c_we=1 and c_addr == MATRIX_DIM**2-1.
- Latency: mac_enable high for the last term at cycle t gives c_we at cycle t+READ_LATENCY+2.
- Throughput: one term per cycle sustained. Back-to-back elements need no bubble; the first_p term of the next element overwrites acc in the same cycle that the previous element's write is presented.
- clear:
  - Zeroes k, the delay-line valids, valid_p and acc, and forces c_we=0 and done=0 in the following cycle.
  - clear and mac_enable in the same cycle: clear wins and that term is dropped.
  - c_data and c_addr are not altered by clear.
- Reset mid-operation: all partial sums are discarded; no write is issued for an interrupted element.
- Operand data is ignored whenever en_d=0 (X-tolerant).

Test Plan:
- Setup for all scenarios: DIM=8, DATA_WIDTH=8, ACC_WIDTH=19, READ_LATENCY=1.
- Ones: all A=1, B=1, FSM sweeps 64 elements.
  - Response: 64 c_we pulses, c_addr 0..63 in order, each c_data=8.
  - done high only alongside c_addr=63.
  - First c_we exactly 3 cycles after the 8th mac_enable.
- Signed extremes:
  - Row A=-128, column B=-128 gives c_data=131072.
  - A=-128, B=127 gives c_data=-130048.
  - A=i-4 and B=3 for i=0..7 gives c_data=-12.
- Gaps: a single element whose 8 mac_enable beats are split by 3 idle cycles gives the same c_data as the contiguous case.
  - Exactly one c_we, 3 cycles after the last beat.
- Clear mid-element: clear after 5 terms, then a fresh 8-term element with all ones.
  - No c_we for the aborted element.
  - Next c_data=8 with the new addr_c.
- Reset mid-element: assert rst asynchronously mid-cycle after 3 terms.
  - Outputs go to 0 immediately.
  - A following full element computes correctly from k=0.
- Latency sweep: repeat the ones test with READ_LATENCY=3.
  - c_we arrives 5 cycles after the last mac_enable; values are unchanged.

Source files
------------

// File: rtl/mmm_mac_writeback.sv
// MAC writeback stage for the matrix-multiply datapath: delays FSM control to
// match A/B read latency, accumulates MATRIX_DIM products, writes each C word.
module mmm_mac_writeback #(
  parameter int MATRIX_DIM   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(MATRIX_DIM),
  parameter int READ_LATENCY = 1
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         mac_enable,
  input  logic [ADDR_WIDTH-1:0]        addr_c,
  input  logic signed [DATA_WIDTH-1:0] a_data,
  input  logic signed [DATA_WIDTH-1:0] b_data,
  output logic                         c_we,
  output logic [ADDR_WIDTH-1:0]        c_addr,
  output logic signed [ACC_WIDTH-1:0]  c_data,
  output logic                         done
);

  localparam int K_WIDTH = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
  localparam int P_WIDTH = 2*DATA_WIDTH;
  localparam logic [K_WIDTH-1:0]    K_LAST     = K_WIDTH'(MATRIX_DIM-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FINAL = ADDR_WIDTH'(MATRIX_DIM*MATRIX_DIM-1);

  logic [READ_LATENCY-1:0] en_sr_q, en_sr_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   addr_sr_d [READ_LATENCY];

  logic [K_WIDTH-1:0]          k_q, k_d;
  logic                        valid_p_q, valid_p_d;
  logic                        first_p_q, first_p_d;
  logic                        last_p_q, last_p_d;
  logic [ADDR_WIDTH-1:0]       addr_p_q, addr_p_d;
  logic signed [P_WIDTH-1:0]   p_q, p_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        c_we_q, c_we_d;
  logic                        done_q, done_d;
  logic [ADDR_WIDTH-1:0]       c_addr_q, c_addr_d;
  logic signed [ACC_WIDTH-1:0] c_data_q, c_data_d;

  logic                        en_d;
  logic [ADDR_WIDTH-1:0]       addr_d;
  logic signed [P_WIDTH-1:0]   a_ext, b_ext, prod;
  logic signed [ACC_WIDTH-1:0] p_ext, acc_base, acc_sum;

  assign en_d   = en_sr_q[READ_LATENCY-1];
  assign addr_d = addr_sr_q[READ_LATENCY-1];

  // Control delay line; clear drops every term still waiting on its read data.
  always_comb begin
    en_sr_d = '0;
    for (int i = 0; i < READ_LATENCY; i++) addr_sr_d[i] = addr_sr_q[i];
    en_sr_d[0]   = mac_enable & ~clear;
    addr_sr_d[0] = addr_c;
    for (int i = 1; i < READ_LATENCY; i++) begin
      en_sr_d[i]   = en_sr_q[i-1] & ~clear;
      addr_sr_d[i] = addr_sr_q[i-1];
    end
  end

  assign a_ext = P_WIDTH'(a_data);
  assign b_ext = P_WIDTH'(b_data);
  assign prod  = a_ext * b_ext;

  always_comb begin
    k_d       = k_q;
    valid_p_d = 1'b0;
    first_p_d = first_p_q;
    last_p_d  = last_p_q;
    addr_p_d  = addr_p_q;
    p_d       = p_q;
    if (clear) begin
      k_d = '0;
    end else if (en_d) begin
      k_d       = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      valid_p_d = 1'b1;
      first_p_d = (k_q == '0);
      last_p_d  = (k_q == K_LAST);
      addr_p_d  = addr_d;
      p_d       = prod;
    end
  end

  assign p_ext    = p_q;
  assign acc_base = first_p_q ? '0 : acc_q;
  assign acc_sum  = acc_base + p_ext;

  // Writeback captures acc_sum directly so the next element's first term can
  // overwrite acc in the same cycle the finished word is presented.
  always_comb begin
    acc_d    = acc_q;
    c_we_d   = 1'b0;
    done_d   = 1'b0;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    if (clear) begin
      acc_d = '0;
    end else if (valid_p_q) begin
      acc_d = acc_sum;
      if (last_p_q) begin
        c_we_d   = 1'b1;
        c_addr_d = addr_p_q;
        c_data_d = acc_sum;
        done_d   = (addr_p_q == ADDR_FINAL);
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      en_sr_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) addr_sr_q[i] <= '0;
      k_q       <= '0;
      valid_p_q <= 1'b0;
      first_p_q <= 1'b0;
      last_p_q  <= 1'b0;
      addr_p_q  <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      c_we_q    <= 1'b0;
      done_q    <= 1'b0;
      c_addr_q  <= '0;
      c_data_q  <= '0;
    end else begin
      en_sr_q   <= en_sr_d;
      for (int i = 0; i < READ_LATENCY; i++) addr_sr_q[i] <= addr_sr_d[i];
      k_q       <= k_d;
      valid_p_q <= valid_p_d;
      first_p_q <= first_p_d;
      last_p_q  <= last_p_d;
      addr_p_q  <= addr_p_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      c_we_q    <= c_we_d;
      done_q    <= done_d;
      c_addr_q  <= c_addr_d;
      c_data_q  <= c_data_d;
    end
  end

  assign c_we   = c_we_q;
  assign done   = done_q;
  assign c_addr = c_addr_q;
  assign c_data = c_data_q;

endmodule

// File: tb/tb_mmm_mac_writeback.sv
// Bench for mmm_mac_writeback: two instances (read latency 1 and 3) share the
// FSM-side stimulus and are checked every cycle against a dot-product scoreboard.
module tb_mmm_mac_writeback;
  localparam int DIM  = 8;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int ACCW = 19;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic mac_enable = 1'b0;
  logic [AW-1:0] addr_c = '0;
  logic signed [DW-1:0] op_a = '0, op_b = '0;
  logic signed [DW-1:0] pa [3];
  logic signed [DW-1:0] pb [3];
  logic we1, done1, we3, done3;
  logic [AW-1:0] ca1, ca3;
  logic signed [ACCW-1:0] cd1, cd3;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory return path: operands appear 1 or 3 cycles after their address.
  always @(posedge CLK) begin
    pa[0] <= op_a; pa[1] <= pa[0]; pa[2] <= pa[1];
    pb[0] <= op_b; pb[1] <= pb[0]; pb[2] <= pb[1];
  end

  mmm_mac_writeback #(.MATRIX_DIM(DIM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_rl1 (
    .CLK(CLK), .rst(rst), .clear(clear), .mac_enable(mac_enable), .addr_c(addr_c),
    .a_data(pa[0]), .b_data(pb[0]), .c_we(we1), .c_addr(ca1), .c_data(cd1), .done(done1));

  mmm_mac_writeback #(.MATRIX_DIM(DIM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_rl3 (
    .CLK(CLK), .rst(rst), .clear(clear), .mac_enable(mac_enable), .addr_c(addr_c),
    .a_data(pa[2]), .b_data(pb[2]), .c_we(we3), .c_addr(ca3), .c_data(cd3), .done(done3));

  typedef struct { int cyc; logic [AW-1:0] addr; int data; } wr_t;
  wr_t q1[$];
  wr_t q3[$];
  int m_k = 0;
  int m_sum = 0;
  logic [AW-1:0] last_addr [2] = '{0, 0};
  int last_data [2] = '{0, 0};
  int we_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int vec_cnt = 0;
  int err_cnt = 0;
  bit mon_on = 0;

  typedef struct {
    logic signed [DW-1:0] a [DIM];
    logic signed [DW-1:0] b [DIM];
    int exp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue-level model: a C word is the sum of the 8 products of one element,
  // written at issue cycle of the last term + latency + 2.
  task automatic model_issue(input bit en, input bit clr, input logic [AW-1:0] addr,
                             input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    wr_t w;
    if (clr) begin
      m_k = 0;
      m_sum = 0;
      while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
      while (q3.size() > 0 && q3[$].cyc > cyc) void'(q3.pop_back());
    end else if (en) begin
      m_sum += int'(a) * int'(b);
      m_k++;
      if (m_k == DIM) begin
        w.addr = addr; w.data = m_sum;
        w.cyc = cyc + 3; q1.push_back(w);
        w.cyc = cyc + 5; q3.push_back(w);
        m_k = 0;
        m_sum = 0;
      end
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q3.delete();
    m_k = 0;
    m_sum = 0;
    last_addr[0] = '0; last_addr[1] = '0;
    last_data[0] = 0;  last_data[1] = 0;
  endtask

  task automatic drive(input bit en, input bit clr, input logic [AW-1:0] addr,
                       input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    @(posedge CLK); #1;
    mac_enable = en; clear = clr; addr_c = addr; op_a = a; op_b = b;
    model_issue(en, clr, addr, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, AW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic sb_check(input int l, input logic we, input logic dn, input logic [AW-1:0] ad,
                          input logic signed [ACCW-1:0] dt);
    bit hit;
    bit exp_dn;
    wr_t w;
    hit = 0;
    if (l == 0) begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin w = q1.pop_front(); hit = 1; end
    end else begin
      if (q3.size() > 0 && q3[0].cyc == cyc) begin w = q3.pop_front(); hit = 1; end
    end
    if (hit) begin
      last_addr[l] = w.addr;
      last_data[l] = w.data;
    end
    exp_dn = hit && (last_addr[l] == AW'(DIM*DIM-1));
    if (we) we_cnt[l]++;
    if (dn) done_cnt[l]++;
    vec_cnt++;
    if (we !== hit || dn !== exp_dn || ad !== last_addr[l] || int'(dt) != last_data[l]) begin
      err_cnt++;
      $display("FAIL sb_rl%0d cyc %0d: got we=%0b done=%0b addr=%0d data=%0d, expected we=%0b done=%0b addr=%0d data=%0d",
               (l == 0) ? 1 : 3, cyc, we, dn, ad, int'(dt), hit, exp_dn, last_addr[l], last_data[l]);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on && !rst) begin
      sb_check(0, we1, done1, ca1, cd1);
      sb_check(1, we3, done3, ca3, cd3);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_we1"}, int'(we1), 0);     chk({tag, "_we3"}, int'(we3), 0);
    chk({tag, "_done1"}, int'(done1), 0); chk({tag, "_done3"}, int'(done3), 0);
    chk({tag, "_addr1"}, int'(ca1), 0);   chk({tag, "_addr3"}, int'(ca3), 0);
    chk({tag, "_data1"}, int'(cd1), 0);   chk({tag, "_data3"}, int'(cd3), 0);
  endtask

  initial begin
    int we0, we0b;
    bit en, clr;
    for (int j = 0; j < DIM; j++) begin
      tbl[0].a[j] = 8'sd1;          tbl[0].b[j] = 8'sd1;
      tbl[1].a[j] = -8'sd128;       tbl[1].b[j] = -8'sd128;
      tbl[2].a[j] = -8'sd128;       tbl[2].b[j] = 8'sd127;
      tbl[3].a[j] = DW'(j - 4);     tbl[3].b[j] = 8'sd3;
    end
    tbl[0].exp = 8;
    tbl[1].exp = 131072;
    tbl[2].exp = -130048;
    tbl[3].exp = -12;

    repeat (3) @(posedge CLK);
    #1 chk_zero("reset");
    rst = 1'b0;
    mon_on = 1;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < DIM; j++) drive(1'b1, 1'b0, AW'(8 + i), tbl[i].a[j], tbl[i].b[j]);
      idle(6);
      chk($sformatf("tbl%0d_data_rl1", i), int'(cd1), tbl[i].exp);
      chk($sformatf("tbl%0d_data_rl3", i), int'(cd3), tbl[i].exp);
      chk($sformatf("tbl%0d_addr_rl1", i), int'(ca1), 8 + i);
    end

    we_cnt[0] = 0; we_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    for (int e = 0; e < DIM*DIM; e++)
      for (int j = 0; j < DIM; j++) drive(1'b1, 1'b0, AW'(e), 8'sd1, 8'sd1);
    idle(6);
    chk("sweep_we_rl1", we_cnt[0], 64);
    chk("sweep_we_rl3", we_cnt[1], 64);
    chk("sweep_done_rl1", done_cnt[0], 1);
    chk("sweep_done_rl3", done_cnt[1], 1);

    // Split element: 4 beats, 3 idle cycles, 4 beats.
    we0 = we_cnt[0]; we0b = we_cnt[1];
    for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 6'd20, 8'sd2, 8'sd3);
    idle(3);
    for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 6'd20, 8'sd2, 8'sd3);
    idle(6);
    chk("gap_data_rl1", int'(cd1), 48);
    chk("gap_data_rl3", int'(cd3), 48);
    chk("gap_we_rl1", we_cnt[0] - we0, 1);
    chk("gap_we_rl3", we_cnt[1] - we0b, 1);

    // Abort after 5 terms; the clear-cycle term is dropped as well.
    we0 = we_cnt[0]; we0b = we_cnt[1];
    for (int j = 0; j < 5; j++) drive(1'b1, 1'b0, 6'd30, 8'sd5, 8'sd5);
    drive(1'b1, 1'b1, 6'd30, 8'sd5, 8'sd5);
    for (int j = 0; j < DIM; j++) drive(1'b1, 1'b0, 6'd31, 8'sd1, 8'sd1);
    idle(6);
    chk("clr_data_rl1", int'(cd1), 8);
    chk("clr_addr_rl3", int'(ca3), 31);
    chk("clr_we_rl1", we_cnt[0] - we0, 1);
    chk("clr_we_rl3", we_cnt[1] - we0b, 1);

    // Asynchronous reset in the middle of an element.
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 6'd40, 8'sd7, 8'sd7);
    idle(1);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    model_reset();
    idle(2);
    rst = 1'b0;
    for (int j = 0; j < DIM; j++) drive(1'b1, 1'b0, 6'd41, 8'sd1, 8'sd1);
    idle(6);
    chk("midrst_data_rl1", int'(cd1), 8);
    chk("midrst_data_rl3", int'(cd3), 8);
    chk("midrst_addr_rl1", int'(ca1), 41);

    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(3) != 0);
      clr = ($urandom_range(63) == 0);
      drive(en, clr, AW'($urandom_range(63)), DW'($urandom), DW'($urandom));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
